// File: rtl/crossing_reg_update_ctrl.sv
// crossing_reg_update_ctrl
// Source-side sequencer for a shared clock-crossing data register.
// Round-robin grants one requester, loads its word into the crossing register,
// waits a settle delay, toggles FLAG_OUT and holds off until ACK_IN matches it.
// ACK_IN is expected to be synchronized into CLK already.
//
// Optional build macro: CROSSING_REG_CTRL_TIMEOUT_EN
//   defined   - WAIT_ACK is bounded by TIMEOUT cycles; on expiry the transfer is
//               abandoned (FLAG_OUT forced to ACK_IN) and TIMEOUT_ERR latches.
//   undefined - WAIT_ACK waits indefinitely; TIMEOUT_ERR is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; grants the next valid requester combinationally
// SETTLE    | register loaded, counting down before the flag toggle
// WAIT_ACK  | flag toggled, waiting for ACK_IN to equal FLAG_OUT
module crossing_reg_update_ctrl #(
    parameter int IDW     = 2,
    parameter int WIDTH   = 32,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024,
    localparam int NREQ   = 2**IDW
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ_VALID,
    input  logic [NREQ*WIDTH-1:0]   REQ_DATA,
    output logic [NREQ-1:0]         REQ_GRANT,
    output logic                    REG_EN,
    output logic [WIDTH-1:0]        REG_D,
    output logic                    FLAG_OUT,
    input  logic                    ACK_IN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [IDW-1:0]          DONE_ID,
    output logic                    TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("SETTLE must be in 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;

`ifdef CROSSING_REG_CTRL_TIMEOUT_EN
    logic [15:0]      tcnt_q, tcnt_d;
    logic             err_q, err_d;
`endif

    // Round-robin search: first valid index starting just above the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = rr_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_q) + k) % NREQ);
            if (!win_found && REQ_VALID[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and combinational outputs; grant is suppressed while RST is high.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        REQ_GRANT = '0;
        REG_EN    = 1'b0;
        REG_D     = '0;
        DONE      = 1'b0;
`ifdef CROSSING_REG_CTRL_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found && !RST) begin
                    REQ_GRANT[win_idx] = 1'b1;
                    REG_EN             = 1'b1;
                    REG_D              = REQ_DATA[int'(win_idx)*WIDTH +: WIDTH];
                    rr_d               = win_idx;
                    id_d               = win_idx;
                    cnt_d              = 8'(SETTLE - 1);
                    state_d            = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    flag_d  = ~flag_q;
                    state_d = ST_WAIT_ACK;
`ifdef CROSSING_REG_CTRL_TIMEOUT_EN
                    tcnt_d  = 16'(TIMEOUT - 1);
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (ACK_IN == flag_q) begin
                    DONE    = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef CROSSING_REG_CTRL_TIMEOUT_EN
                else if (tcnt_q == 16'd0) begin
                    // Abandon: realign the flag with the destination so the
                    // next transfer starts from a matched pair.
                    flag_d  = ACK_IN;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rr_q    <= IDW'(NREQ - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

`ifdef CROSSING_REG_CTRL_TIMEOUT_EN
    // WAIT_ACK down-counter and sticky timeout error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign FLAG_OUT = flag_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE_ID  = id_q;

endmodule

// File: doc/crossing_reg_update_ctrl.md
Name: crossing_reg_update_ctrl

Overview:
Source-side sequencer for a shared clock-crossing data register. It round-robin arbitrates among NREQ requesters and loads the winner's word into the crossing register through REG_EN/REG_D. After a settle delay it toggles a request flag toward the destination domain, then holds off further loads until the destination's acknowledge toggle returns. ACK_IN arrives already synchronized into CLK by an external two-flop synchronizer.

Parameters:
IDW, 2, requester index width; NREQ = 2**IDW requesters
WIDTH, 32, data width of the crossing register
SETTLE, 2, cycles between register load and flag toggle; legal range 1..255
TIMEOUT, 1024, WAIT_ACK cycle limit; used only with the optional feature; legal range 1..65535

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
REQ_VALID  in  NREQ  per-requester update request; held until granted
REQ_DATA  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
REQ_GRANT  out  NREQ  one-hot, one-cycle acceptance pulse
REG_EN  out  1  load enable to the crossing register
REG_D  out  WIDTH  data to the crossing register
FLAG_OUT  out  1  request toggle to the destination domain
ACK_IN  in  1  synchronized acknowledge toggle from the destination domain
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle pulse when the ack matches
DONE_ID  out  IDW  index of the completed requester; valid with DONE
TIMEOUT_ERR  out  1  sticky timeout error; tied 0 when the feature is off

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE, FLAG_OUT=0, rr pointer=NREQ-1 so requester 0 has priority first.
  - Counters=0, TIMEOUT_ERR=0.
  - REQ_GRANT, REG_EN, DONE, BUSY=0; REG_D=0; DONE_ID=0.
- Reset mid-operation abandons the transfer and returns FLAG_OUT to 0. The destination must be reset concurrently.
- States are IDLE, SETTLE and WAIT_ACK.
- IDLE, any REQ_VALID high in cycle T:
  - Select the first valid index searching from rr+1 upward, modulo NREQ.
  - REQ_GRANT[i]=1, REG_EN=1, REG_D=REQ_DATA[i]. These are combinational in cycle T, so the crossing register captures at the end of T.
  - Registered at the end of T: rr=i, id=i, cnt=SETTLE-1, state=SETTLE.
- IDLE, no request: REG_EN=0 and REG_D=0.
- SETTLE (cycles T+1..T+SETTLE): cnt decrements each cycle. When cnt==0, FLAG_OUT toggles at that edge (visible from T+SETTLE+1) and state goes to WAIT_ACK.
- WAIT_ACK: stay while ACK_IN != FLAG_OUT. When ACK_IN == FLAG_OUT, assert DONE=1 with DONE_ID=id in that same cycle; next state is IDLE.
- Earliest next grant is the cycle after DONE, so the minimum period per transfer is SETTLE+2 cycles.
- REQ_VALID and REQ_DATA changes outside IDLE are ignored. A requester is never granted twice for one assertion unless it re-requests after its grant.
- ACK_IN toggles seen in IDLE or SETTLE are ignored and cause no error.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that stays valid gets its turn within NREQ transfers.
- NREQ=1 degenerates to a single requester, with rr fixed at 0.

Optional Feature:
CROSSING_REG_CTRL_TIMEOUT_EN
- Defined:
  - A WAIT_ACK cycle counter starts at 0 on entry.
  - When it reaches TIMEOUT-1 without a match, FLAG_OUT is forced to equal ACK_IN (the transfer is abandoned) and TIMEOUT_ERR is set, sticky until RST.
  - DONE is not asserted for the abandoned transfer, and state returns to IDLE.
- Undefined: no counter is built, WAIT_ACK waits indefinitely, and TIMEOUT_ERR is constant 0.

Test Plan:
- Reset, then REQ_VALID=4'b0001, data0=32'hA5A5_0001, SETTLE=2, ACK echoes FLAG_OUT 3 cycles later.
  - REQ_GRANT=0001 and REG_EN=1 with REG_D=A5A50001 in cycle T.
  - FLAG_OUT 0->1 visible at T+3.
  - DONE=1 with DONE_ID=0 at T+6; BUSY low at T+7.
- REQ_VALID=4'b1111 held, ack echoed immediately → grants in order 0,1,2,3,0, each exactly SETTLE+2=4 cycles apart.
- RST asserted during SETTLE after granting requester 2 → next cycle IDLE, FLAG_OUT=0, BUSY=0; the next grant goes to requester 0 again.
- ACK_IN toggled while IDLE, then request 1 → no DONE and no error. WAIT_ACK completes only when ACK_IN equals the new FLAG_OUT.
- With the macro defined and TIMEOUT=16, ack never returned → TIMEOUT_ERR=1 after 16 WAIT_ACK cycles, FLAG_OUT==ACK_IN, no DONE; the following request proceeds normally with TIMEOUT_ERR still 1.
